// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master controller: sequencer states and default sizing.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Wide enough for the full 1..255 timeout range.
    localparam int TIMER_W = 8;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; the head entry is readable combinationally so the
// sequencer can launch a transfer on the same edge that pops it.
module apb_cmd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == FULL_COUNT);
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: queues CPU commands and replays them as registered APB transfers.
// Build option: define APB_TIMEOUT_EN to abort ACCESS phases stalled for TIMEOUT_CYC cycles.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              cpu_psel,
    output logic              cpu_penable,
    output logic              cpu_pwrite,
    output logic [ADDR_W-1:0] cpu_paddr,
    output logic [DATA_W-1:0] cpu_pwdata,
    input  logic              cpu_pready,
    input  logic              cpu_pslverr,
    input  logic [DATA_W-1:0] cpu_prdata
);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    logic [CMD_W-1:0]  push_cmd;
    logic [CMD_W-1:0]  head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    apb_state_t        state_reg, state_next;
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic              pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              xfer_done;
    logic              launch;
    logic              timeout_hit;

    assign cmd_ready = cpu_rstn && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign push_cmd  = {cmd_write, cmd_addr, cmd_wdata};
    assign {head_write, head_addr, head_wdata} = head_cmd;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (cpu_clk),
        .rstn      (cpu_rstn),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               rsp_timeout_reg;

    // Counts ACCESS edges already spent waiting; cleared whenever not in ACCESS.
    always_comb begin
        timer_next = '0;
        if (state_reg == ACCESS) begin
            timer_next = timer_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ACCESS) && !cpu_pready && (timer_reg == TIMEOUT_LAST);

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            timer_reg       <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            timer_reg       <= timer_next;
            rsp_timeout_reg <= timeout_hit;
        end
    end

    assign rsp_timeout = rsp_timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        fifo_pop       = 1'b0;
        xfer_done      = 1'b0;
        launch         = 1'b0;

        case (state_reg)
            IDLE: begin
                launch = !fifo_empty;
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
                xfer_done = cpu_pready || timeout_hit;
                if (xfer_done) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = cpu_pready ? cpu_pslverr : 1'b1;
                    rsp_rdata_next = (cpu_pready && !pwrite_reg) ? cpu_prdata : '0;
                    launch         = !fifo_empty;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A finished transfer either chains straight into the next SETUP or parks the bus.
        if (launch) begin
            fifo_pop     = 1'b1;
            state_next   = SETUP;
            psel_next    = 1'b1;
            penable_next = 1'b0;
            pwrite_next  = head_write;
            paddr_next   = head_addr;
            pwdata_next  = head_wdata;
        end else if (xfer_done) begin
            state_next   = IDLE;
            psel_next    = 1'b0;
            penable_next = 1'b0;
            pwrite_next  = 1'b0;
            pwdata_next  = '0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            state_reg     <= IDLE;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign cpu_psel    = psel_reg;
    assign cpu_penable = penable_reg;
    assign cpu_pwrite  = pwrite_reg;
    assign cpu_paddr   = paddr_reg;
    assign cpu_pwdata  = pwdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign busy        = (state_reg != IDLE) || !fifo_empty;

endmodule
